// File: rtl/uart_tx_scheduler_pkg.sv
// Shared constants for the UART transmit scheduler: FSM encodings, widths and
// the round-robin pointer wrap helper.
package uart_tx_scheduler_pkg;

  localparam int unsigned NUM_SRC_DEF = 4;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned ID_W        = 3;

  localparam logic [1:0] ST_ARB       = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Index following idx in a ring of n sources.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] idx,
                                              input int unsigned     n);
    return (idx == ID_W'(n - 1)) ? '0 : idx + ID_W'(1);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after i_ptr, as a
// one-hot grant plus index. The caller owns the pointer register.
module rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_SRC-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_valid
);

  localparam logic [ID_W:0] N_L = (ID_W + 1)'(NUM_SRC);

  logic [ID_W:0] w_sum;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_sum   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_sum = {1'b0, i_ptr} + (ID_W + 1)'(k);
      if (w_sum >= N_L) w_sum = w_sum - N_L;
      if (!o_valid && (|(i_req & (NUM_SRC'(1) << w_sum)))) begin
        o_valid = 1'b1;
        o_idx   = w_sum[ID_W-1:0];
      end
    end
  end

  assign o_gnt = o_valid ? (NUM_SRC'(1) << o_idx) : '0;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one byte-serial UART transmitter between NUM_SRC requesters with
// round-robin arbitration, message locking and start/lock timeouts.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SRC       = NUM_SRC_DEF,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_SRC-1:0]   i_src_req,
  input  logic [NUM_SRC-1:0]   i_src_last,
  input  logic [8*NUM_SRC-1:0] i_src_data,
  output logic [NUM_SRC-1:0]   o_src_ack,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_din,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic [ID_W-1:0]      o_grant_id,
  output logic                 o_locked,
  output logic                 o_err_start,
  output logic                 o_lock_abort
);

  localparam logic [CNT_W-1:0] LOCK_LIM  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TIMEOUT - 1);

  logic [1:0]         r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_grant_id;
  logic               r_locked;
  logic               r_last;
  logic [7:0]         r_tx_din;
  logic [CNT_W-1:0]   r_cnt;

  logic [1:0]         w_state_nxt;
  logic [NUM_SRC-1:0] w_arb_gnt;
  logic [ID_W-1:0]    w_arb_idx;
  logic               w_arb_valid;
  logic [NUM_SRC-1:0] w_gid_oh;
  logic [NUM_SRC-1:0] w_win_oh;
  logic               w_own_req;
  logic               w_win_last;
  logic [7:0]         w_win_data;
  logic [ID_W-1:0]    w_win_idx;
  logic               w_grant;
  logic               w_lock_to;
  logic               w_start_to;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .i_req   (i_src_req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_gid_oh   = NUM_SRC'(1) << r_grant_id;
  assign w_own_req  = |(i_src_req & w_gid_oh);
  // While locked only the lock holder may win; the arbiter result is ignored.
  assign w_win_oh   = r_locked ? w_gid_oh : w_arb_gnt;
  assign w_win_last = |(i_src_last & w_win_oh);
  assign w_win_data = 8'(i_src_data >> {w_win_idx, 3'b000});

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_win_idx   = r_grant_id;
    w_lock_to   = 1'b0;
    w_start_to  = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (r_locked) begin
          if (w_own_req)             w_grant   = 1'b1;
          else if (r_cnt >= LOCK_LIM) w_lock_to = 1'b1;
        end else if (w_arb_valid) begin
          w_grant   = 1'b1;
          w_win_idx = w_arb_idx;
        end
        if (w_grant) w_state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (i_tx_active) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_cnt >= START_LIM) begin
          w_start_to  = 1'b1;
          w_state_nxt = ST_ARB;
        end
      end
      ST_WAIT_DONE: if (i_tx_done) w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_ARB;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_locked   <= 1'b0;
      r_last     <= 1'b0;
      r_tx_din   <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_cnt != '1)       r_cnt <= r_cnt + CNT_W'(1);

      if (w_grant) begin
        r_grant_id <= w_win_idx;
        r_tx_din   <= w_win_data;
        r_last     <= w_win_last;
        // Locked continuation bytes leave the pointer where the message began.
        if (!r_locked) r_ptr <= rr_next(w_win_idx, NUM_SRC);
      end

      if (r_state == ST_LAUNCH)       r_locked <= ~r_last;
      else if (w_lock_to || w_start_to) r_locked <= 1'b0;
    end
  end

  assign o_tx_start   = (r_state == ST_LAUNCH);
  assign o_src_ack    = (r_state == ST_LAUNCH) ? w_gid_oh : '0;
  assign o_tx_din     = r_tx_din;
  assign o_busy       = (r_state != ST_ARB);
  assign o_grant_id   = r_grant_id;
  assign o_locked     = r_locked;
  assign o_err_start  = w_start_to;
  assign o_lock_abort = w_lock_to;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: a transaction-level arbitration model
// fills an expectation queue, and a monitor checks launches and timeout pulses.
module tb_uart_tx_scheduler;

  localparam int NS  = 4;
  localparam int LT  = 40;
  localparam int STO = 8;
  localparam int KBYTE = 0, KABORT = 1, KERR = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NS-1:0]   src_req, src_last, src_ack;
  logic [8*NS-1:0] src_data;
  logic            tx_start, tx_active, tx_done, busy, locked, err_start, lock_abort;
  logic [7:0]      tx_din;
  logic [2:0]      grant_id;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_SRC       (NS),
    .LOCK_TIMEOUT  (LT),
    .START_TIMEOUT (STO)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_src_req    (src_req),
    .i_src_last   (src_last),
    .i_src_data   (src_data),
    .o_src_ack    (src_ack),
    .o_tx_start   (tx_start),
    .o_tx_din     (tx_din),
    .i_tx_active  (tx_active),
    .i_tx_done    (tx_done),
    .o_busy       (busy),
    .o_grant_id   (grant_id),
    .o_locked     (locked),
    .o_err_start  (err_start),
    .o_lock_abort (lock_abort)
  );

  typedef struct { logic [7:0] data; logic last; } byte_t;
  typedef struct { int kind; int src; logic [7:0] data; logic lk; } exp_t;

  byte_t sq[NS][$];   // what each source presents
  byte_t mq[NS][$];   // model copy, drained by run_model
  exp_t  expq[$];
  int    m_ptr = 0;
  int    m_lock = -1;
  int    n_pass = 0, n_total = 0;
  int    cyc = 0;
  int    req_rise[NS];
  int    start_cyc = 0;
  bit    dead = 0;
  int    tx_len = 20;
  bit    txm_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic load(input int s, input logic [7:0] d, input logic l);
    byte_t b;
    b.data = d;
    b.last = l;
    sq[s].push_back(b);
    mq[s].push_back(b);
  endtask

  // Message-level model: round-robin from the pointer, stick with a locked
  // source until its last byte, abort when it runs dry, drop on dead tx.
  function automatic void run_model();
    byte_t b;
    int w;
    while (1) begin
      if (m_lock >= 0) begin
        if (mq[m_lock].size() == 0) begin
          expq.push_back('{KABORT, m_lock, 8'h00, 1'b0});
          m_lock = -1;
          continue;
        end
        w = m_lock;
      end else begin
        w = -1;
        for (int k = 0; k < NS; k++) begin
          int c;
          c = (m_ptr + k) % NS;
          if (w < 0 && mq[c].size() != 0) w = c;
        end
        if (w < 0) break;
        m_ptr = (w + 1) % NS;
      end
      b = mq[w].pop_front();
      expq.push_back('{KBYTE, w, b.data, !b.last});
      if (dead) begin
        expq.push_back('{KERR, w, 8'h00, 1'b0});
        m_lock = -1;
      end else begin
        m_lock = b.last ? -1 : w;
      end
    end
  endfunction

  // Source drivers: present queue front, advance on ack.
  initial begin
    src_req = '0; src_last = '0; src_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (rst_n && src_ack[i] === 1'b1 && sq[i].size() != 0) sq[i].delete(0);
        if (sq[i].size() != 0) begin
          if (!src_req[i]) req_rise[i] = cyc;
          src_req[i]          = 1'b1;
          src_data[8*i +: 8]  = sq[i][0].data;
          src_last[i]         = sq[i][0].last;
        end else begin
          src_req[i]          = 1'b0;
          src_data[8*i +: 8]  = 8'h00;
          src_last[i]         = 1'b0;
        end
      end
    end
  end

  // Transmitter: active the cycle after start, done pulse tx_len cycles later.
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start === 1'b1 && !dead) begin
        txm_busy = 1;
        @(posedge clk);
        #1 tx_active = 1'b1;
        repeat (tx_len - 1) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
        tx_active = 1'b0;
        txm_busy  = 0;
      end
    end
  end

  // Monitor
  initial begin
    int   since_start = 0, since_done = 0;
    bit   in_frame = 0, post_end = 0, lk_pend = 0;
    logic lk_exp = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      since_start++;
      since_done++;
      if (!rst_n) begin
        in_frame = 0; post_end = 0; lk_pend = 0;
        continue;
      end
      if (lk_pend) begin chk("locked_next", locked, lk_exp); lk_pend = 0; end
      if (post_end) begin chk("busy_after_end", busy, 0); post_end = 0; end
      if (tx_start) begin
        since_start = 0;
        start_cyc   = cyc;
        chk("start_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("kind_at_start", e.kind, KBYTE);
          chk("src_ack", src_ack, 1 << e.src);
          chk("grant_id", grant_id, e.src);
          chk("tx_din", tx_din, e.data);
          lk_pend = 1;
          lk_exp  = e.lk;
        end
        in_frame = 1;
      end else begin
        chk("ack_idle", src_ack, 0);
        if (in_frame) chk("busy_in_frame", busy, 1);
      end
      if (tx_done) since_done = 0;
      if (tx_done && in_frame && !tx_start) begin in_frame = 0; post_end = 1; end
      if (err_start) begin
        chk("err_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("kind_at_err", e.kind, KERR);
        end
        chk("err_delay", since_start, STO);
        in_frame = 0; post_end = 1; lk_pend = 1; lk_exp = 1'b0;
      end
      if (lock_abort) begin
        chk("abort_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("kind_at_abort", e.kind, KABORT);
        end
        chk("abort_delay", since_done, LT);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_src_ack", src_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_start", err_start, 0);
    chk("rst_lock_abort", lock_abort, 0);
    chk("rst_tx_din", tx_din, 0);
    chk("rst_expq_empty", expq.size(), 0);
    rst_n = 1'b1;
    expq.delete();
    m_ptr  = 0;
    m_lock = -1;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    bit q_empty;
    for (int n = 0; n < 4000 && !ok; n++) begin
      @(negedge clk);
      q_empty = 1;
      for (int i = 0; i < NS; i++) if (sq[i].size() != 0) q_empty = 0;
      if (q_empty && expq.size() == 0 && !busy && !txm_busy) ok = 1;
    end
    chk({name, "_complete"}, ok, 1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int tot;
    do_reset();

    // Single byte and request-to-start latency
    load(0, 8'hA5, 1'b1);
    run_model();
    wait_idle("single");
    chk("start_latency", start_cyc - req_rise[0], 1);

    // Locked 3-byte message from src1 while src0 waits
    load(1, 8'h11, 1'b0); load(1, 8'h12, 1'b0); load(1, 8'h13, 1'b1);
    load(0, 8'h0F, 1'b1);
    run_model();
    wait_idle("lock_msg");

    // Fairness from reset pointer: 0,1,3,0,1,3
    do_reset();
    for (int r = 0; r < 2; r++) begin
      load(0, 8'h20 + 8'(r), 1'b1);
      load(1, 8'h30 + 8'(r), 1'b1);
      load(3, 8'h40 + 8'(r), 1'b1);
    end
    run_model();
    wait_idle("fairness");

    // Lock abort: src2 leaves a message open, src3 pending
    load(2, 8'h5C, 1'b0);
    load(3, 8'h6D, 1'b1);
    run_model();
    wait_idle("lock_abort");

    // Dead transmitter
    dead = 1;
    load(0, 8'h5A, 1'b0);
    run_model();
    wait_idle("dead_tx");
    chk("dead_locked_clear", locked, 0);
    dead = 0;

    // Reset during WAIT_DONE, then arbitration restarts at pointer 0
    load(2, 8'h3C, 1'b1);
    run_model();
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (busy && tx_active && !tx_start) ok = 1;
    end
    chk("reached_wait_done", ok, 1);
    repeat (3) @(negedge clk);
    do_reset();
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (!txm_busy) ok = 1;
    end
    chk("tx_frame_drained", ok, 1);
    load(3, 8'h77, 1'b1);
    load(1, 8'h88, 1'b1);
    run_model();
    wait_idle("post_reset");

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      tx_len = int'($urandom_range(24, 2));
      tot = 0;
      for (int s = 0; s < NS; s++) begin
        int nmsg;
        nmsg = int'($urandom_range(2, 0));
        for (int m = 0; m < nmsg; m++) begin
          int len;
          len = int'($urandom_range(3, 1));
          for (int b = 0; b < len; b++) begin
            load(s, 8'($urandom), (b == len - 1));
            tot++;
          end
        end
        if ($urandom_range(5, 0) == 0) begin
          load(s, 8'($urandom), 1'b0);
          tot++;
        end
      end
      if (tot == 0) load(int'($urandom_range(NS - 1, 0)), 8'($urandom), 1'b1);
      run_model();
      wait_idle("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
